// File: rtl/ffsr_pkg.sv
// Shared state encoding and thermometer-code helpers for the ffsr_pulse scheduler.
// Pure declarations; no timing or flow control of its own.
package ffsr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int THERMO_MAX = 64;

    // Count k sets the top k bits of the low 'size'-bit field (bit size-1 fills first).
    function automatic logic [THERMO_MAX-1:0] thermo(input int count, input int size);
        logic [THERMO_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < THERMO_MAX; i++) begin
            if (i < size && i < count) begin
                t[size - 1 - i] = 1'b1;
            end
        end
        return t;
    endfunction

    function automatic int clamp(input int count, input int max_count);
        return (count > max_count) ? max_count : count;
    endfunction

endpackage

// File: rtl/ffsr_pulse.sv
// Thermometer-coded pulse counter: rst loads init synchronously, inc/dec step by one.
// One-cycle latency from command to out; no backpressure, saturation is the caller's job.
module ffsr_pulse #(
    parameter int INPUT_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INPUT_SIZE-1:0] init,
    input  logic                  inc,
    input  logic                  dec,
    output logic [INPUT_SIZE-1:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= init;
        end else if (inc && !dec) begin
            out <= {1'b1, out[INPUT_SIZE-1:1]};
        end else if (dec && !inc) begin
            out <= {out[INPUT_SIZE-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ffsr_pulse_sched_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
// Zero latency; requesters not picked simply keep asserting until served.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] winner
);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ffsr_pulse_sched.sv
// Owns one ffsr_pulse register: sequences load, round-robins inc/dec among requesters.
// Grant is same-cycle; saturating commands are granted but dropped; no other backpressure.
module ffsr_pulse_sched
    import ffsr_pkg::*;
#(
    parameter int INPUT_SIZE = 16,
    parameter int N_REQ      = 4,
    parameter int CNT_W      = $clog2(INPUT_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CNT_W-1:0]      load_val,
    input  logic [N_REQ-1:0]      req_inc,
    input  logic [N_REQ-1:0]      req_dec,
    output logic [N_REQ-1:0]      gnt,
    output logic                  reg_rst,
    output logic [INPUT_SIZE-1:0] reg_init,
    output logic                  reg_inc,
    output logic                  reg_dec,
    input  logic [INPUT_SIZE-1:0] reg_out,
    output logic                  valid,
    output logic                  drop,
    output logic                  mismatch
);

    localparam int               PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INPUT_SIZE);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(N_REQ - 1);

    state_t                  state;
    logic [CNT_W-1:0]        shadow;
    logic [CNT_W-1:0]        load_cnt;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        winner;
    logic [N_REQ-1:0]        arb_gnt;
    logic                    any_gnt;
    logic                    win_inc;
    logic                    win_dec;
    logic [THERMO_MAX-1:0]   init_full;
    logic [THERMO_MAX-1:0]   shadow_full;
    logic                    unused_hi;

    assign load_cnt    = CNT_W'(clamp(int'(load_val), INPUT_SIZE));
    assign init_full   = thermo(int'(load_cnt), INPUT_SIZE);
    assign shadow_full = thermo(int'(shadow), INPUT_SIZE);
    assign unused_hi   = ^{init_full[THERMO_MAX-1:INPUT_SIZE], shadow_full[THERMO_MAX-1:INPUT_SIZE]};

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req_inc | req_dec),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    assign any_gnt = |arb_gnt;
    assign win_inc = req_inc[winner];
    assign win_dec = req_dec[winner];

    // A pending load pre-empts arbitration for the whole RUN cycle.
    always_comb begin
        gnt      = '0;
        reg_inc  = 1'b0;
        reg_dec  = 1'b0;
        drop     = 1'b0;
        valid    = (state == RUN);
        reg_rst  = (state == IDLE) || (state == LOAD);
        reg_init = (state == LOAD) ? init_full[INPUT_SIZE-1:0] : '0;
        if (state == RUN && !load && any_gnt) begin
            gnt = arb_gnt;
            if (win_inc && !win_dec) begin
                if (shadow < CNT_MAX) begin
                    reg_inc = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (win_dec && !win_inc) begin
                if (shadow != '0) begin
                    reg_dec = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shadow   <= '0;
            rr_ptr   <= '0;
            mismatch <= 1'b0;
        end else begin
            if (state == RUN && reg_out != shadow_full[INPUT_SIZE-1:0]) begin
                mismatch <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shadow <= load_cnt;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (load) begin
                        state <= LOAD;
                    end else if (any_gnt) begin
                        rr_ptr <= (winner == PTR_TOP) ? '0 : winner + 1'b1;
                        if (reg_inc) begin
                            shadow <= shadow + 1'b1;
                        end else if (reg_dec) begin
                            shadow <= shadow - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffsr_pulse_sched.sv
// Scoreboard bench: driver pushes expected per-cycle outputs from a count/pointer model,
// a negedge monitor pops and compares against the DUT and the real ffsr_pulse.
module tb_ffsr_pulse_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [CW-1:0] load_val;
    logic [N-1:0]  req_inc;
    logic [N-1:0]  req_dec;
    logic [N-1:0]  gnt;
    logic          reg_rst;
    logic [W-1:0]  reg_init;
    logic          reg_inc;
    logic          reg_dec;
    logic          valid;
    logic          drop;
    logic          mismatch;
    logic [W-1:0]  pulse_q;
    logic [W-1:0]  reg_out_bus;
    logic          inj;

    always #5 clk = ~clk;

    ffsr_pulse #(.INPUT_SIZE(W)) u_reg (
        .clk  (clk),
        .rst  (reg_rst),
        .init (reg_init),
        .inc  (reg_inc),
        .dec  (reg_dec),
        .out  (pulse_q)
    );

    // Corrupted view of the register: one thermometer step away from the true value.
    assign reg_out_bus = !inj ? pulse_q :
                         (pulse_q == 16'hFFFF) ? {pulse_q[14:0], 1'b0} : {1'b1, pulse_q[15:1]};

    ffsr_pulse_sched #(.INPUT_SIZE(W), .N_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .req_inc  (req_inc),
        .req_dec  (req_dec),
        .gnt      (gnt),
        .reg_rst  (reg_rst),
        .reg_init (reg_init),
        .reg_inc  (reg_inc),
        .reg_dec  (reg_dec),
        .reg_out  (reg_out_bus),
        .valid    (valid),
        .drop     (drop),
        .mismatch (mismatch)
    );

    typedef struct {
        logic [N-1:0] gnt;
        logic         ri;
        logic         rd;
        logic         drop;
        logic         valid;
        logic         rrst;
        logic         mm;
        logic [W-1:0] init;
        logic         chk_q;
        logic [W-1:0] q;
    } exp_t;

    exp_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: phase 0 idle, 1 load, 2 settle, 3 run.
    int   m_phase = 0;
    int   m_cnt   = 0;
    int   m_ptr   = 0;
    bit   m_mm    = 1'b0;

    function automatic logic [W-1:0] therm(input int k);
        logic [31:0] v;
        v = ((32'd1 << k) - 32'd1) << (W - k);
        return v[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic l, input logic [CW-1:0] lv,
                        input logic [N-1:0] ri, input logic [N-1:0] rd);
        exp_t e;
        int   w;
        load     = l;
        load_val = lv;
        req_inc  = ri;
        req_dec  = rd;
        e        = '{default: '0};
        e.mm     = m_mm;
        if (rst) begin
            e.rrst  = 1'b1;
            e.mm    = 1'b0;
            m_phase = 0;
            m_cnt   = 0;
            m_ptr   = 0;
            m_mm    = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    e.rrst = 1'b1;
                    if (l) m_phase = 1;
                end
                1: begin
                    e.rrst  = 1'b1;
                    m_cnt   = (int'(lv) > W) ? W : int'(lv);
                    e.init  = therm(m_cnt);
                    m_phase = 2;
                end
                2: m_phase = 3;
                default: begin
                    e.valid = 1'b1;
                    e.chk_q = 1'b1;
                    e.q     = therm(m_cnt);
                    if (inj) m_mm = 1'b1;
                    if (l) begin
                        m_phase = 1;
                    end else begin
                        w = -1;
                        for (int k = 0; k < N; k++) begin
                            int i;
                            i = (m_ptr + k) % N;
                            if (w < 0 && (ri[i] || rd[i])) w = i;
                        end
                        if (w >= 0) begin
                            e.gnt[w] = 1'b1;
                            m_ptr    = (w + 1) % N;
                            if (ri[w] && !rd[w]) begin
                                if (m_cnt == W) e.drop = 1'b1;
                                else begin e.ri = 1'b1; m_cnt++; end
                            end else if (rd[w] && !ri[w]) begin
                                if (m_cnt == 0) e.drop = 1'b1;
                                else begin e.rd = 1'b1; m_cnt--; end
                            end
                        end
                    end
                end
            endcase
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [CW-1:0] v);
        step(1'b1, v, '0, '0);
        step(1'b0, v, '0, '0);
        step(1'b0, v, '0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("reg_inc", 32'(reg_inc), 32'(e.ri));
                chk("reg_dec", 32'(reg_dec), 32'(e.rd));
                chk("drop", 32'(drop), 32'(e.drop));
                chk("valid", 32'(valid), 32'(e.valid));
                chk("reg_rst", 32'(reg_rst), 32'(e.rrst));
                chk("reg_init", 32'(reg_init), 32'(e.init));
                chk("mismatch", 32'(mismatch), 32'(e.mm));
                if (e.chk_q) chk("reg_out", 32'(pulse_q), 32'(e.q));
            end
        end
    end

    initial begin : driver
        int           mode;
        logic [N-1:0] ri;
        logic [N-1:0] rd;
        rst      = 1'b1;
        inj      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        req_inc  = '0;
        req_dec  = '0;
        @(posedge clk);
        #1;
        step(1'b0, '0, '0, '0);
        step(1'b0, '0, '0, '0);
        rst = 1'b0;
        step(1'b0, '0, '0, '0);

        do_load(5'd5);
        step(1'b0, '0, '0, '0);
        chk("load5_reg", 32'(pulse_q), 32'h0000F800);

        do_load(5'd3);
        repeat (8) step(1'b0, '0, 4'hF, '0);
        chk("inc8_reg", 32'(pulse_q), 32'h0000FFE0);

        do_load(5'd15);
        repeat (3) step(1'b0, '0, 4'b0100, '0);
        chk("sat_hi_reg", 32'(pulse_q), 32'h0000FFFF);

        do_load(5'd0);
        step(1'b0, '0, '0, 4'b0010);
        chk("sat_lo_reg", 32'(pulse_q), 32'h00000000);

        do_load(5'd7);
        step(1'b0, '0, 4'b0001, 4'b0001);
        step(1'b0, '0, 4'b0011, '0);

        inj = 1'b1;
        step(1'b0, '0, '0, '0);
        inj = 1'b0;
        repeat (3) step(1'b0, '0, '0, '0);
        rst = 1'b1;
        step(1'b0, '0, '0, '0);
        rst = 1'b0;
        step(1'b0, '0, '0, '0);

        do_load(5'd31);
        step(1'b0, '0, '0, 4'b1000);

        mode = 0;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) mode = $urandom_range(0, 2);
            rst = ($urandom_range(0, 199) == 0);
            ri  = N'($urandom_range(0, 15));
            rd  = N'($urandom_range(0, 15));
            if (mode == 1) rd = rd & N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            if (mode == 2) ri = ri & N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            step(($urandom_range(0, 29) == 0) || (m_phase == 0 && $urandom_range(0, 3) == 0),
                 CW'($urandom_range(0, 31)), ri, rd);
        end
        rst = 1'b0;
        step(1'b0, '0, '0, '0);
        @(negedge clk);
        #1;
        chk("drain", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
